mux_4to1: RTL and testbench



---
 rtl/mux_pkg.sv | 29 ++
 rtl/decoder_2x4.sv | 20 ++
 rtl/mux_4to1.sv | 43 ++++
 tb/tb_mux_4to1.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the mux/decoder library: lane geometry, select type and a generic
// lane-extraction helper usable by muxes of any lane count and width.
package mux_pkg;

    localparam int unsigned SEL_W   = 2;
    localparam int unsigned N_LANES = 4;
    localparam int unsigned MAX_W   = 64;

    typedef logic [SEL_W-1:0] sel_t;

    // Returns lane s of a packed lane vector; bits above width are zero.
    function automatic logic [MAX_W-1:0] get_lane(
        input logic [N_LANES*MAX_W-1:0] i,
        input sel_t                     s,
        input int unsigned              width
    );
        logic [MAX_W-1:0] lane;
        int unsigned      base;
        lane = '0;
        base = int'(s) * width;
        for (int unsigned b = 0; b < MAX_W; b++) begin
            if (b < width && (base + b) < N_LANES * MAX_W) begin
                lane[b] = i[base + b];
            end
        end
        return lane;
    endfunction

endpackage

// File: rtl/decoder_2x4.sv
// 2-to-4 one-hot decoder; exactly one output bit is high for every select value.
module decoder_2x4
    import mux_pkg::*;
(
    input  logic [SEL_W-1:0]   s,
    output logic [N_LANES-1:0] sel_onehot
);

    always_comb begin
        sel_onehot = '0;
        unique case (s)
            2'b00:   sel_onehot = 4'b0001;
            2'b01:   sel_onehot = 4'b0010;
            2'b10:   sel_onehot = 4'b0100;
            2'b11:   sel_onehot = 4'b1000;
            default: sel_onehot = '0;
        endcase
    end

endmodule

// File: rtl/mux_4to1.sv
// Four-lane selector with a combinational output and a one-cycle registered copy plus valid.
module mux_4to1
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_LANES*WIDTH-1:0] i,
    input  logic [SEL_W-1:0]         s,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         F,
    output logic [N_LANES-1:0]       sel_onehot,
    output logic [WIDTH-1:0]         f_q,
    output logic                     out_valid
);

    decoder_2x4 u_decoder (
        .s          (s),
        .sel_onehot (sel_onehot)
    );

    // AND-OR select: the one-hot decode guarantees a single lane contributes, no priority chain.
    always_comb begin
        F = '0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            F = F | (i[k*WIDTH +: WIDTH] & {WIDTH{sel_onehot[k]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                f_q <= F;
            end
        end
    end

endmodule

// File: tb/tb_mux_4to1.sv
// Directed self-checking bench for mux_4to1 at WIDTH=1 and WIDTH=8.
module tb_mux_4to1;

    typedef struct {
        logic [3:0] i;
        logic [1:0] s;
        logic       f;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  s = 2'b00;
    logic [3:0]  i1 = '0;
    logic [31:0] i8 = '0;

    logic        f1, f_q1, ov1;
    logic [3:0]  oh1;
    logic [7:0]  f8, f_q8;
    logic [3:0]  oh8;
    logic        ov8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_4to1 #(.WIDTH(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i          (i1),
        .s          (s),
        .in_valid   (in_valid),
        .F          (f1),
        .sel_onehot (oh1),
        .f_q        (f_q1),
        .out_valid  (ov1)
    );

    mux_4to1 #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i          (i8),
        .s          (s),
        .in_valid   (in_valid),
        .F          (f8),
        .sel_onehot (oh8),
        .f_q        (f_q8),
        .out_valid  (ov8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs[8];
        logic [7:0] exp8[4];
        logic [3:0] ti;
        logic [3:0] one;

        vecs[0] = '{4'b0001, 2'b00, 1'b1};
        vecs[1] = '{4'b1110, 2'b00, 1'b0};
        vecs[2] = '{4'b0010, 2'b01, 1'b1};
        vecs[3] = '{4'b1101, 2'b01, 1'b0};
        vecs[4] = '{4'b0100, 2'b10, 1'b1};
        vecs[5] = '{4'b1011, 2'b10, 1'b0};
        vecs[6] = '{4'b1000, 2'b11, 1'b1};
        vecs[7] = '{4'b0111, 2'b11, 1'b0};
        exp8[0] = 8'hA1;
        exp8[1] = 8'hB2;
        exp8[2] = 8'hC3;
        exp8[3] = 8'hD4;
        one = 4'b0001;

        // Reset state (a real negedge on rst_n).
        #1 rst_n = 1'b0;
        #1;
        check("rst_f_q1", {31'b0, f_q1}, 32'd0);
        check("rst_out_valid1", {31'b0, ov1}, 32'd0);
        check("rst_f_q8", {24'b0, f_q8}, 32'd0);
        check("rst_out_valid8", {31'b0, ov8}, 32'd0);

        // Select/complement sweep, applied while still in reset: F must not depend on it.
        for (int v = 0; v < 8; v++) begin
            i1 = vecs[v].i;
            s  = vecs[v].s;
            #5;
            check($sformatf("sweep_F[%0d]", v), {31'b0, f1}, {31'b0, vecs[v].f});
        end

        // All 64 {i, s} combinations.
        for (int n = 0; n < 64; n++) begin
            ti = n[5:2];
            i1 = ti;
            s  = n[1:0];
            #1;
            check($sformatf("exh_F[%0d]", n), {31'b0, f1}, {31'b0, ti[s]});
            check($sformatf("exh_onehot[%0d]", n), {28'b0, oh1}, {28'b0, one << s});
        end

        // Registered path.
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        i1 = 4'b0100;
        s = 2'b10;
        @(posedge clk); #1;
        check("reg_f_q_capture", {31'b0, f_q1}, 32'd1);
        check("reg_out_valid_high", {31'b0, ov1}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        i1 = 4'b0000;
        @(posedge clk); #1;
        check("reg_f_q_hold", {31'b0, f_q1}, 32'd1);
        check("reg_out_valid_low", {31'b0, ov1}, 32'd0);
        check("reg_F_follows", {31'b0, f1}, 32'd0);

        // Asynchronous reset between edges while out_valid is high.
        @(negedge clk);
        in_valid = 1'b1;
        i1 = 4'b1000;
        s = 2'b11;
        @(posedge clk); #1;
        check("async_pre_out_valid", {31'b0, ov1}, 32'd1);
        check("async_pre_f_q", {31'b0, f_q1}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_f_q1", {31'b0, f_q1}, 32'd0);
        check("async_out_valid1", {31'b0, ov1}, 32'd0);
        check("async_out_valid8", {31'b0, ov8}, 32'd0);
        check("async_F_tracks", {31'b0, f1}, 32'd1);
        i1 = 4'b0111;
        #1;
        check("async_F_tracks2", {31'b0, f1}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // WIDTH=8 combinational select.
        i8 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        for (int k = 0; k < 4; k++) begin
            s = k[1:0];
            #1;
            check($sformatf("w8_F[%0d]", k), {24'b0, f8}, {24'b0, exp8[k]});
            check($sformatf("w8_onehot[%0d]", k), {28'b0, oh8}, {28'b0, one << k});
        end

        // WIDTH=8 streamed burst, one result per cycle.
        @(negedge clk);
        in_valid = 1'b1;
        s = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("burst_f_q[%0d]", k), {24'b0, f_q8}, {24'b0, exp8[k]});
            check($sformatf("burst_out_valid[%0d]", k), {31'b0, ov8}, 32'd1);
            @(negedge clk);
            if (k < 3) s = 2'(k + 1);
            else in_valid = 1'b0;
        end
        @(posedge clk); #1;
        check("burst_end_out_valid", {31'b0, ov8}, 32'd0);
        check("burst_end_f_q_hold", {24'b0, f_q8}, 32'hD4);

        // in_valid toggling each cycle: out_valid mirrors it one cycle later.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = k[0];
            @(posedge clk); #1;
            check($sformatf("toggle_out_valid[%0d]", k), {31'b0, ov1}, {31'b0, k[0]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
